// File: rtl/note_rom_arbiter.sv
// note_rom_arbiter: round-robin share of one synchronous note-divider ROM among VOICES sequencers.
// Ports: clk/rst_n; per-voice req/req_idx in, ack/voice_divider/voice_active out;
//        rom_en/rom_addr out and rom_data in (data valid the cycle after rom_en).
// Latency: req to ack is 3 cycles through the ROM, 1 cycle on a cache hit. One grant per cycle;
//          a voice holds req until ack and is never back-pressured otherwise.
// Optional feature: define NOTE_ROM_CACHE_EN to keep a per-voice last-index cache.
module note_rom_arbiter #(
  parameter int VOICES = 4,
  parameter int IDX_W  = 9,
  parameter int DATA_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [VOICES-1:0]        req,
  input  logic [VOICES*IDX_W-1:0]  req_idx,
  output logic [VOICES-1:0]        ack,
  output logic                     rom_en,
  output logic [IDX_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [VOICES*DATA_W-1:0] voice_divider,
  output logic [VOICES-1:0]        voice_active
);

  localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  typedef logic [PTR_W-1:0] vid_t;

  // Arbitration and ROM pipeline state
  vid_t                          ptr_q, ptr_d;
  logic [VOICES-1:0]             pending_q, pending_d;
  logic                          s1_valid_q, s1_valid_d;
  vid_t                          s1_voice_q, s1_voice_d;
  logic                          s2_valid_q, s2_valid_d;
  vid_t                          s2_voice_q, s2_voice_d;
  logic [IDX_W-1:0]              rom_addr_q, rom_addr_d;
  logic [VOICES-1:0]             ack_q, ack_d;
  logic [VOICES-1:0][DATA_W-1:0] div_q, div_d;

  logic [VOICES-1:0]             eligible;
  logic [VOICES-1:0]             hit;
  logic [VOICES-1:0]             cand;
  logic                          win_found;
  vid_t                          win_id;
  logic [IDX_W-1:0]              win_idx;

  // A voice with a lookup already in flight must not be granted again.
  assign eligible = req & ~pending_q;

`ifdef NOTE_ROM_CACHE_EN
  logic [VOICES-1:0][IDX_W-1:0]  cache_idx_q, cache_idx_d;
  logic [VOICES-1:0]             cache_vld_q, cache_vld_d;

  // Hit detection is kept apart from the cache update so that the
  // hit -> arbitration -> cache-update chain stays acyclic per block.
  always_comb begin
    hit = '0;
    for (int v = 0; v < VOICES; v++) begin
      hit[v] = eligible[v] & cache_vld_q[v] &
               (req_idx[v*IDX_W +: IDX_W] == cache_idx_q[v]);
    end
  end

  // The valid bit drops at grant and rises only when that lookup lands, so a
  // hit always returns the divider that is already in the holding register.
  always_comb begin
    cache_idx_d = cache_idx_q;
    cache_vld_d = cache_vld_q;
    if (win_found) begin
      cache_idx_d[win_id] = win_idx;
      cache_vld_d[win_id] = 1'b0;
    end
    if (s2_valid_q) begin
      cache_vld_d[s2_voice_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_idx_q <= '0;
      cache_vld_q <= '0;
    end else begin
      cache_idx_q <= cache_idx_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`else
  assign hit = '0;
`endif

  // Round-robin pick: scan upward from ptr with wrap; hit voices are served
  // by the cache and never take the ROM port.
  always_comb begin
    cand      = eligible & ~hit;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < VOICES; k++) begin
      if (!win_found && cand[(int'(ptr_q) + k) % VOICES]) begin
        win_found = 1'b1;
        win_id    = vid_t'((int'(ptr_q) + k) % VOICES);
      end
    end
    win_idx = req_idx[int'(win_id)*IDX_W +: IDX_W];
  end

  always_comb begin
    ptr_d      = ptr_q;
    pending_d  = pending_q;
    s1_valid_d = win_found;
    s1_voice_d = s1_voice_q;
    rom_addr_d = rom_addr_q;
    s2_valid_d = s1_valid_q;
    s2_voice_d = s1_voice_q;
    div_d      = div_q;
    ack_d      = hit;

    if (win_found) begin
      s1_voice_d        = win_id;
      rom_addr_d        = win_idx;
      pending_d[win_id] = 1'b1;
      ptr_d             = (int'(win_id) == VOICES-1) ? '0 : win_id + vid_t'(1);
    end

    // rom_data is only trusted in the cycle after the read strobe.
    // The completing voice is pending, so it can never be this cycle's winner.
    if (s2_valid_q) begin
      div_d[s2_voice_q]     = rom_data;
      pending_d[s2_voice_q] = 1'b0;
      ack_d[s2_voice_q]     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      pending_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_voice_q <= '0;
      s2_valid_q <= 1'b0;
      s2_voice_q <= '0;
      rom_addr_q <= '0;
      ack_q      <= '0;
      div_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      s1_valid_q <= s1_valid_d;
      s1_voice_q <= s1_voice_d;
      s2_valid_q <= s2_valid_d;
      s2_voice_q <= s2_voice_d;
      rom_addr_q <= rom_addr_d;
      ack_q      <= ack_d;
      div_q      <= div_d;
    end
  end

  assign ack           = ack_q;
  assign rom_en        = s1_valid_q;
  assign rom_addr      = rom_addr_q;
  assign voice_divider = div_q;

  // A zero divider encodes a rest.
  always_comb begin
    voice_active = '0;
    for (int v = 0; v < VOICES; v++) begin
      voice_active[v] = |div_q[v];
    end
  end

endmodule

// File: tb/tb_note_rom_arbiter.sv
`timescale 1ns/1ps
module tb_note_rom_arbiter;
  localparam int VOICES = 4;
  localparam int IDX_W  = 9;
  localparam int DATA_W = 10;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [VOICES-1:0]        req = '0;
  logic [VOICES*IDX_W-1:0]  req_idx = '0;
  logic [VOICES-1:0]        ack;
  logic                     rom_en;
  logic [IDX_W-1:0]         rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic [VOICES*DATA_W-1:0] voice_divider;
  logic [VOICES-1:0]        voice_active;

  int n_cmp = 0;
  int n_bad = 0;
  bit auto_drop = 1'b1;
  logic [VOICES-1:0] last_ack = '0;

  always #5 clk = ~clk;

  note_rom_arbiter #(.VOICES(VOICES), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_idx(req_idx), .ack(ack),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .voice_divider(voice_divider), .voice_active(voice_active)
  );

  function automatic int rom_fn(int idx);
    case (idx)
      8:       return 157;
      9:       return 176;
      10:      return 198;
      11:      return 210;
      23:      return 354;
      54:      return 612;
      100:     return 0;
      300:     return 777;
      511:     return 1023;
      default: return (idx * 37 + 5) % 1024;
    endcase
  endfunction

  // Synchronous ROM; garbage on unstrobed cycles.
  always @(posedge clk) begin
    if (rom_en) rom_data <= DATA_W'(rom_fn(int'(rom_addr)));
    else        rom_data <= DATA_W'($urandom);
  end

  // Reference model: time-stamped events, one slot per cycle in a small ring.
  int mcyc = 0;
  int m_ptr = 0;
  int m_free  [VOICES];
  int m_cidx  [VOICES];
  int m_cfrom [VOICES];
  bit m_chave [VOICES];
  int m_div   [VOICES];
  bit x_en  [8];
  int x_addr[8];
  logic [VOICES-1:0] x_ack[8];
  bit x_w   [8];
  int x_wv  [8];
  int x_wd  [8];

  always @(posedge clk) begin : model
    int n, s, w, j, idx;
    logic [VOICES-1:0] elig, hitv;
    n = mcyc + 1;
    s = n % 8;
    if (!rst_n) begin
      m_ptr = 0;
      for (int v = 0; v < VOICES; v++) begin
        m_free[v] = 0; m_chave[v] = 0; m_div[v] = 0; m_cidx[v] = 0; m_cfrom[v] = 0;
      end
      for (int i = 0; i < 8; i++) begin
        x_en[i] = 0; x_ack[i] = '0; x_w[i] = 0; x_addr[i] = 0; x_wv[i] = 0; x_wd[i] = 0;
      end
    end else begin
      x_en[(n+3)%8] = 0; x_ack[(n+3)%8] = '0; x_w[(n+3)%8] = 0;
      if (x_w[s]) m_div[x_wv[s]] = x_wd[s];
      hitv = '0;
      w = -1;
      for (int v = 0; v < VOICES; v++) elig[v] = req[v] && (n >= m_free[v]);
`ifdef NOTE_ROM_CACHE_EN
      for (int v = 0; v < VOICES; v++)
        if (elig[v] && m_chave[v] && n >= m_cfrom[v] &&
            int'(req_idx[v*IDX_W +: IDX_W]) == m_cidx[v]) hitv[v] = 1'b1;
`endif
      x_ack[s] = x_ack[s] | hitv;
      for (int k = 0; k < VOICES; k++) begin
        j = (m_ptr + k) % VOICES;
        if (w < 0 && elig[j] && !hitv[j]) w = j;
      end
      if (w >= 0) begin
        idx = int'(req_idx[w*IDX_W +: IDX_W]);
        x_en[s] = 1; x_addr[s] = idx;
        x_ack[(n+2)%8][w] = 1'b1;
        x_w[(n+2)%8] = 1; x_wv[(n+2)%8] = w; x_wd[(n+2)%8] = rom_fn(idx);
        m_free[w] = n + 3;
        m_cidx[w] = idx; m_chave[w] = 1; m_cfrom[w] = n + 3;
        m_ptr = (w + 1) % VOICES;
      end
    end
    mcyc = n;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: outputs sampled at the falling edge against the model.
  task automatic step();
    int s;
    @(posedge clk);
    @(negedge clk);
    last_ack = ack;
    if (!rst_n) begin
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_ack", ack, 0);
      chk("rst_divider", voice_divider, 0);
      chk("rst_active", voice_active, 0);
    end else begin
      s = mcyc % 8;
      chk("rom_en", rom_en, x_en[s]);
      if (x_en[s]) chk("rom_addr", rom_addr, x_addr[s]);
      chk("ack", ack, x_ack[s]);
      for (int v = 0; v < VOICES; v++) begin
        chk("divider", voice_divider[v*DATA_W +: DATA_W], m_div[v]);
        chk("active", voice_active[v], m_div[v] != 0);
      end
    end
    if (auto_drop) req = req & ~ack;
  endtask

  task automatic set_idx(input int v, input int idx);
    req_idx[v*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_ack(input int v, input int max, output int lat, output int en_cnt);
    lat = -1;
    en_cnt = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (rom_en) en_cnt++;
      if (last_ack[v]) begin
        lat = i;
        break;
      end
    end
  endtask

  typedef struct {
    int v;
    int idx;
    int exp_div;
    bit exp_act;
    int exp_lat;
  } vec_t;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t tbl[4];
    int lat, en_cnt, ng, prev, g, c0, c1, acks, pick;
    int gaddr[8];
    int gstep[8];
    int astep[VOICES];

    tbl[0] = '{2, 23, 354, 1'b1, 3};
    tbl[1] = '{0, 100, 0, 1'b0, 3};
    tbl[2] = '{3, 300, 777, 1'b1, 3};
    tbl[3] = '{1, 511, 1023, 1'b1, 3};

    step();
    step();
    rst_n = 1'b1;
    step();

    // Single requests, including a rest note.
    for (int i = 0; i < 4; i++) begin
      set_idx(tbl[i].v, tbl[i].idx);
      req[tbl[i].v] = 1'b1;
      wait_ack(tbl[i].v, 10, lat, en_cnt);
      chk("tbl_latency", lat, tbl[i].exp_lat);
      chk("tbl_rom_en_count", en_cnt, 1);
      chk("tbl_ack_vector", last_ack, VOICES'(1) << tbl[i].v);
      chk("tbl_divider", voice_divider[tbl[i].v*DATA_W +: DATA_W], tbl[i].exp_div);
      chk("tbl_active", voice_active[tbl[i].v], tbl[i].exp_act);
      step();
      step();
    end

    // Full contention from reset: grant order 0..3, acks at t+3..t+6.
    do_reset();
    for (int v = 0; v < VOICES; v++) begin
      set_idx(v, 8 + v);
      astep[v] = -1;
    end
    req = '1;
    ng = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rom_en && ng < 8) begin
        gaddr[ng] = int'(rom_addr);
        gstep[ng] = k;
        ng++;
      end
      for (int v = 0; v < VOICES; v++) if (last_ack[v] && astep[v] < 0) astep[v] = k;
    end
    chk("cont_grant_count", ng, 4);
    for (int v = 0; v < VOICES; v++) begin
      if (v < ng) begin
        chk("cont_grant_addr", gaddr[v], 8 + v);
        chk("cont_grant_step", gstep[v], 1 + v);
      end
      chk("cont_ack_step", astep[v], 3 + v);
    end
    chk("cont_div0", voice_divider[0*DATA_W +: DATA_W], 157);
    chk("cont_div1", voice_divider[1*DATA_W +: DATA_W], 176);
    chk("cont_div2", voice_divider[2*DATA_W +: DATA_W], 198);
    chk("cont_div3", voice_divider[3*DATA_W +: DATA_W], 210);

    // Fairness: voices 0 and 1 hold req; voice 0 uses even, voice 1 odd indices.
    auto_drop = 1'b0;
    req = 4'b0011;
    prev = -1; c0 = 0; c1 = 0;
    for (int i = 0; i < 30; i++) begin
      set_idx(0, 120 + 2*i);
      set_idx(1, 121 + 2*i);
      step();
      if (rom_en) begin
        g = int'(rom_addr[0]);
        if (prev >= 0) chk("rr_alternate", g, 1 - prev);
        prev = g;
        if (g == 0) c0++; else c1++;
      end
    end
    chk("rr_balance", ((c0 - c1) <= 1) && ((c1 - c0) <= 1), 1);
    chk("rr_throughput", (c0 + c1) >= 18, 1);
    req = '0;
    auto_drop = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Reset one cycle after a grant: nothing from the aborted lookup survives.
    set_idx(3, 77);
    req[3] = 1'b1;
    step();
    chk("mid_grant", rom_en, 1);
    step();
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("mid_rst_rom_en", rom_en, 0);
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_divider", voice_divider, 0);
    chk("mid_rst_active", voice_active, 0);
    step();
    step();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack != 0) acks++;
    end
    chk("mid_no_ack_after", acks, 0);
    chk("mid_no_write_after", voice_divider, 0);

`ifdef NOTE_ROM_CACHE_EN
    // Repeat lookup of the same index is served from the cache.
    set_idx(1, 54);
    req[1] = 1'b1;
    wait_ack(1, 10, lat, en_cnt);
    chk("cache_first_latency", lat, 3);
    chk("cache_first_div", voice_divider[1*DATA_W +: DATA_W], 612);
    step();
    req[1] = 1'b1;
    wait_ack(1, 10, lat, en_cnt);
    chk("cache_hit_latency", lat, 1);
    chk("cache_hit_rom_en", en_cnt, 0);
    chk("cache_hit_div", voice_divider[1*DATA_W +: DATA_W], 612);
    step();
`endif

    // Random traffic against the model, including idx changes while pending
    // and occasional early req drops.
    for (int i = 0; i < 400; i++) begin
      for (int v = 0; v < VOICES; v++) begin
        if (!req[v]) begin
          if ($urandom_range(3) == 0) begin
            case ($urandom_range(5))
              0: pick = 5;
              1: pick = 6;
              2: pick = 23;
              3: pick = 54;
              4: pick = 100;
              default: pick = int'($urandom_range(511));
            endcase
            set_idx(v, pick);
            req[v] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          set_idx(v, int'($urandom_range(511)));
        end else if ($urandom_range(63) == 0) begin
          req[v] = 1'b0;
        end
      end
      step();
    end
    req = '0;
    for (int i = 0; i < 6; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
